gen_timer_counter: RTL and testbench

//  Parametrised up/down timer-counter; successor to the fixed 16-bit free-running counter.

---
 rtl/gen_timer_counter_pkg.sv | 33 +++
 rtl/gen_timer_counter_if.sv | 35 +++
 rtl/gen_timer_counter_tick_prescaler.sv | 39 +++
 rtl/gen_timer_counter.sv | 120 ++++++++++++
 tb/tb_gen_timer_counter.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gen_timer_counter_pkg.sv
// gen_timer_pkg: shared types and constants for the general-purpose timer-counter.
//   tmode_t      counting mode at terminal (WRAP, SAT, ONESHOT, reserved = WRAP)
//   tstate_t     run-control state of the counter
//   PRESCALE_MAX largest supported prescale divide ratio
//   clamp_div()  folds an out-of-range divide ratio into 1..PRESCALE_MAX
package gen_timer_pkg;

   localparam int unsigned PRESCALE_MAX = 65536;

   typedef enum logic [1:0] {
      TM_WRAP    = 2'd0,
      TM_SAT     = 2'd1,
      TM_ONESHOT = 2'd2,
      TM_RSVD    = 2'd3
   } tmode_t;

   // ST_SAT_HOLD remembers that a saturating hold already reported its terminal
   // event, so tc/ov/cmp_hit fire only on the first step at terminal.
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_SAT_HOLD = 2'd1,
      ST_HALT     = 2'd2
   } tstate_t;

   function automatic int unsigned clamp_div(input int unsigned d);
      if (d < 1)
         return 1;
      if (d > PRESCALE_MAX)
         return PRESCALE_MAX;
      return d;
   endfunction

endpackage

// File: rtl/gen_timer_counter_if.sv
// gen_timer_counter_if: control/status bundle of the timer-counter.
//   en, clr, load, load_val, up, mode, cmp_val, ov_clr   controller -> timer
//   count, tc, ov, cmp_hit, running                      timer -> controller
// Modports: master (controller side), slave (timer side).
interface gen_timer_counter_if
   import gen_timer_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) ();

   logic             en;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             up;
   tmode_t           mode;
   logic [WIDTH-1:0] cmp_val;
   logic             ov_clr;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             ov;
   logic             cmp_hit;
   logic             running;

   modport master (
      output en, clr, load, load_val, up, mode, cmp_val, ov_clr,
      input  count, tc, ov, cmp_hit, running
   );

   modport slave (
      input  en, clr, load, load_val, up, mode, cmp_val, ov_clr,
      output count, tc, ov, cmp_hit, running
   );

endinterface

// File: rtl/gen_timer_counter_tick_prescaler.sv
// tick_prescaler: divides enabled clocks by DIV.
//   clk    in  clock, rising edge
//   nrst   in  asynchronous active-low reset
//   en     in  advance the phase counter; phase frozen when low
//   sclr   in  synchronous phase clear
//   strobe out combinational, high on the DIV-th enabled clock (en when DIV=1)
module tick_prescaler #(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic nrst,
   input  logic en,
   input  logic sclr,
   output logic strobe
);

   if (DIV <= 1) begin : g_bypass
      logic unused_ports;
      assign unused_ports = ^{clk, nrst, sclr};
      assign strobe       = en;
   end else begin : g_div
      localparam int unsigned   PW   = $clog2(DIV);
      localparam logic [PW-1:0] LAST = PW'(DIV - 1);

      logic [PW-1:0] phase;

      assign strobe = en & (phase == LAST);

      always_ff @(posedge clk or negedge nrst) begin
         if (!nrst)
            phase <= '0;
         else if (sclr)
            phase <= '0;
         else if (en)
            phase <= strobe ? '0 : phase + PW'(1);
      end
   end

endmodule

// File: rtl/gen_timer_counter.sv
// gen_timer_counter: parametrised up/down timer-counter with prescale, sync
// clear/load, WRAP/SAT/ONESHOT terminal behaviour, sticky overflow and
// terminal-count / compare-match strobes.
//   clk   in  clock, rising edge
//   nrst  in  asynchronous active-low reset
//   bus   slave side of gen_timer_counter_if (controls in, count/status out)
// Parameters: WIDTH (2..32), MAX_VALUE (up-count terminal, 1..2^WIDTH-1),
// PRESCALE (enabled clocks per step, 1..PRESCALE_MAX).
module gen_timer_counter
   import gen_timer_pkg::*;
#(
   parameter int unsigned      WIDTH     = 16,
   parameter logic [WIDTH-1:0] MAX_VALUE = '1,
   parameter int unsigned      PRESCALE  = 1
) (
   input  logic               clk,
   input  logic               nrst,
   gen_timer_counter_if.slave bus
);

   localparam int unsigned DIV = clamp_div(PRESCALE);

   tstate_t          state, state_nxt;
   logic [WIDTH-1:0] count_q, count_nxt;
   logic [WIDTH-1:0] load_clip;
   logic             tc_q, tc_nxt;
   logic             hit_q, hit_nxt;
   logic             ov_q, ov_nxt;
   logic             strobe, step, at_term, halted;
   logic             evt, ov_set;

   tick_prescaler #(
      .DIV(DIV)
   ) u_presc (
      .clk   (clk),
      .nrst  (nrst),
      .en    (bus.en),
      .sclr  (bus.clr | bus.load),
      .strobe(strobe)
   );

   assign halted    = (state == ST_HALT);
   assign step      = bus.en & strobe & ~halted;
   assign at_term   = bus.up ? (count_q == MAX_VALUE) : (count_q == '0);
   assign load_clip = (bus.load_val > MAX_VALUE) ? MAX_VALUE : bus.load_val;

   // evt marks a step that produced a reportable count value: every ordinary
   // step and every terminal step except a repeated saturating hold.
   always_comb begin
      state_nxt = state;
      count_nxt = count_q;
      tc_nxt    = 1'b0;
      evt       = 1'b0;
      ov_set    = 1'b0;
      if (bus.clr) begin
         count_nxt = '0;
         state_nxt = ST_RUN;
      end else if (bus.load) begin
         count_nxt = load_clip;
         state_nxt = ST_RUN;
      end else if (step) begin
         if (!at_term) begin
            count_nxt = bus.up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            state_nxt = ST_RUN;
            evt       = 1'b1;
         end else begin
            case (bus.mode)
               TM_SAT: begin
                  if (state != ST_SAT_HOLD) begin
                     tc_nxt    = 1'b1;
                     ov_set    = 1'b1;
                     evt       = 1'b1;
                     state_nxt = ST_SAT_HOLD;
                  end
               end
               TM_ONESHOT: begin
                  tc_nxt    = 1'b1;
                  ov_set    = 1'b1;
                  evt       = 1'b1;
                  state_nxt = ST_HALT;
               end
               default: begin
                  count_nxt = bus.up ? '0 : MAX_VALUE;
                  tc_nxt    = 1'b1;
                  ov_set    = 1'b1;
                  evt       = 1'b1;
                  state_nxt = ST_RUN;
               end
            endcase
         end
      end
   end

   assign hit_nxt = evt & (count_nxt == bus.cmp_val);
   // a new overflow wins over a simultaneous ov_clr
   assign ov_nxt  = ov_set | (ov_q & ~bus.ov_clr);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state   <= ST_RUN;
         count_q <= '0;
         tc_q    <= 1'b0;
         hit_q   <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state   <= state_nxt;
         count_q <= count_nxt;
         tc_q    <= tc_nxt;
         hit_q   <= hit_nxt;
         ov_q    <= ov_nxt;
      end
   end

   assign bus.count   = count_q;
   assign bus.tc      = tc_q;
   assign bus.cmp_hit = hit_q;
   assign bus.ov      = ov_q;
   assign bus.running = bus.en & ~halted;

endmodule

// File: tb/tb_gen_timer_counter.sv
// Four timer instances with different WIDTH/MAX_VALUE/PRESCALE share one
// stimulus stream; a reference model predicts each one's outputs per edge.
module tb_gen_timer_counter;
   import gen_timer_pkg::*;

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   gen_timer_counter_if #(.WIDTH(16)) if0 ();
   gen_timer_counter_if #(.WIDTH(4))  if1 ();
   gen_timer_counter_if #(.WIDTH(8))  if2 ();
   gen_timer_counter_if #(.WIDTH(4))  if3 ();

   gen_timer_counter #(.WIDTH(16), .MAX_VALUE(16'hFFFF), .PRESCALE(1))
      u0 (.clk(clk), .nrst(nrst), .bus(if0.slave));
   gen_timer_counter #(.WIDTH(4), .MAX_VALUE(4'd15), .PRESCALE(1))
      u1 (.clk(clk), .nrst(nrst), .bus(if1.slave));
   gen_timer_counter #(.WIDTH(8), .MAX_VALUE(8'h80), .PRESCALE(1))
      u2 (.clk(clk), .nrst(nrst), .bus(if2.slave));
   gen_timer_counter #(.WIDTH(4), .MAX_VALUE(4'd5), .PRESCALE(3))
      u3 (.clk(clk), .nrst(nrst), .bus(if3.slave));

   int unsigned      WD   [4] = '{16, 4, 8, 4};
   longint unsigned  MAXV [4] = '{65535, 15, 128, 5};
   int unsigned      PRS  [4] = '{1, 1, 1, 3};

   logic [31:0] act_cnt [4];
   logic        act_tc  [4];
   logic        act_ov  [4];
   logic        act_hit [4];
   logic        act_run [4];

   assign act_cnt[0] = 32'(if0.count);
   assign act_cnt[1] = 32'(if1.count);
   assign act_cnt[2] = 32'(if2.count);
   assign act_cnt[3] = 32'(if3.count);
   assign act_tc[0]  = if0.tc;      assign act_tc[1]  = if1.tc;
   assign act_tc[2]  = if2.tc;      assign act_tc[3]  = if3.tc;
   assign act_ov[0]  = if0.ov;      assign act_ov[1]  = if1.ov;
   assign act_ov[2]  = if2.ov;      assign act_ov[3]  = if3.ov;
   assign act_hit[0] = if0.cmp_hit; assign act_hit[1] = if1.cmp_hit;
   assign act_hit[2] = if2.cmp_hit; assign act_hit[3] = if3.cmp_hit;
   assign act_run[0] = if0.running; assign act_run[1] = if1.running;
   assign act_run[2] = if2.running; assign act_run[3] = if3.running;

   // stimulus shared by all instances
   logic        en_v, clr_v, load_v, up_v, ov_clr_v;
   logic [1:0]  mode_v;
   logic [31:0] ldv_v, cmp_v;

   typedef struct {
      longint unsigned cnt;
      bit              ov;
      bit              halted;
      bit              sat_done;
      int unsigned     ph;
   } mstate_t;
   mstate_t ms [4];

   typedef struct packed {
      logic [31:0] cnt;
      logic        tc;
      logic        ov;
      logic        hit;
      logic        run;
   } exp_t;
   exp_t sbq [$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive();
      if0.en = en_v; if0.clr = clr_v; if0.load = load_v; if0.up = up_v;
      if0.ov_clr = ov_clr_v; if0.mode = tmode_t'(mode_v);
      if0.load_val = ldv_v[15:0]; if0.cmp_val = cmp_v[15:0];
      if1.en = en_v; if1.clr = clr_v; if1.load = load_v; if1.up = up_v;
      if1.ov_clr = ov_clr_v; if1.mode = tmode_t'(mode_v);
      if1.load_val = ldv_v[3:0]; if1.cmp_val = cmp_v[3:0];
      if2.en = en_v; if2.clr = clr_v; if2.load = load_v; if2.up = up_v;
      if2.ov_clr = ov_clr_v; if2.mode = tmode_t'(mode_v);
      if2.load_val = ldv_v[7:0]; if2.cmp_val = cmp_v[7:0];
      if3.en = en_v; if3.clr = clr_v; if3.load = load_v; if3.up = up_v;
      if3.ov_clr = ov_clr_v; if3.mode = tmode_t'(mode_v);
      if3.load_val = ldv_v[3:0]; if3.cmp_val = cmp_v[3:0];
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         ms[i].cnt = 0; ms[i].ov = 0; ms[i].halted = 0; ms[i].sat_done = 0; ms[i].ph = 0;
      end
   endtask

   // Predicts the state after the coming edge from the current inputs.
   task automatic model_step(input int i);
      longint unsigned mask, ldv, cmp;
      mstate_t s;
      bit tc, hit, set, stp, term;
      exp_t e;
      mask = (64'd1 << WD[i]) - 1;
      ldv  = longint'(ldv_v) & mask;
      cmp  = longint'(cmp_v) & mask;
      s = ms[i];
      tc = 0; hit = 0; set = 0; stp = 0;
      if (clr_v) begin
         s.cnt = 0; s.ph = 0; s.halted = 0; s.sat_done = 0;
      end else if (load_v) begin
         s.cnt = (ldv > MAXV[i]) ? MAXV[i] : ldv;
         s.ph = 0; s.halted = 0; s.sat_done = 0;
      end else if (en_v) begin
         if (s.ph + 1 == PRS[i]) begin
            s.ph = 0;
            stp  = !s.halted;
         end else begin
            s.ph = s.ph + 1;
         end
      end
      if (stp) begin
         term = up_v ? (s.cnt == MAXV[i]) : (s.cnt == 0);
         if (!term) begin
            s.cnt = up_v ? s.cnt + 1 : s.cnt - 1;
            s.sat_done = 0;
            hit = (s.cnt == cmp);
         end else if (mode_v == 2'd1) begin
            if (!s.sat_done) begin
               tc = 1; set = 1; hit = (s.cnt == cmp); s.sat_done = 1;
            end
         end else if (mode_v == 2'd2) begin
            tc = 1; set = 1; hit = (s.cnt == cmp); s.halted = 1;
         end else begin
            s.cnt = up_v ? 0 : MAXV[i];
            tc = 1; set = 1; hit = (s.cnt == cmp); s.sat_done = 0;
         end
      end
      if (set)
         s.ov = 1;
      else if (ov_clr_v)
         s.ov = 0;
      ms[i] = s;
      e.cnt = 32'(s.cnt);
      e.tc  = tc;
      e.ov  = s.ov;
      e.hit = hit;
      e.run = en_v & !s.halted;
      sbq.push_back(e);
   endtask

   task automatic cycle();
      @(negedge clk);
      drive();
      for (int i = 0; i < 4; i++)
         model_step(i);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // monitor: compares every instance once per edge an expectation exists
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
               e = sbq.pop_front();
               chk($sformatf("mon%0d.count", i),   act_cnt[i], e.cnt);
               chk($sformatf("mon%0d.tc", i),      act_tc[i],  e.tc);
               chk($sformatf("mon%0d.ov", i),      act_ov[i],  e.ov);
               chk($sformatf("mon%0d.cmp_hit", i), act_hit[i], e.hit);
               chk($sformatf("mon%0d.running", i), act_run[i], e.run);
            end
         end
      end
   end

   initial begin
      int r;
      en_v = 0; clr_v = 0; load_v = 0; up_v = 1; ov_clr_v = 0; mode_v = 2'd0;
      ldv_v = '0; cmp_v = 32'h5A5A;
      drive();
      model_reset();
      #3;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reset%0d.count", i), act_cnt[i], 0);
         chk($sformatf("reset%0d.tc", i),    act_tc[i],  0);
         chk($sformatf("reset%0d.ov", i),    act_ov[i],  0);
         chk($sformatf("reset%0d.hit", i),   act_hit[i], 0);
      end
      en_v = 1; drive(); #1;
      chk("reset.running_follows_en", act_run[0], 1);
      en_v = 0; drive();
      @(negedge clk);
      nrst = 1;

      // WRAP up on the 4-bit instance
      en_v = 1; up_v = 1; mode_v = 2'd0;
      repeat (15) cycle();
      cycle(); settle();
      chk("wrap.count", act_cnt[1], 0);
      chk("wrap.tc", act_tc[1], 1);
      chk("wrap.ov", act_ov[1], 1);
      cycle(); settle();
      chk("wrap.tc_pulse", act_tc[1], 0);
      chk("wrap.ov_sticky", act_ov[1], 1);

      // SAT down from 2
      en_v = 0; load_v = 1; ldv_v = 2; up_v = 0; mode_v = 2'd1; ov_clr_v = 1;
      cycle(); settle();
      chk("sat.load", act_cnt[1], 2);
      chk("sat.ov_cleared", act_ov[1], 0);
      load_v = 0; ov_clr_v = 0; en_v = 1;
      cycle(); cycle(); settle();
      chk("sat.reach0_count", act_cnt[1], 0);
      chk("sat.reach0_tc", act_tc[1], 0);
      cycle(); settle();
      chk("sat.first_count", act_cnt[1], 0);
      chk("sat.first_tc", act_tc[1], 1);
      chk("sat.first_ov", act_ov[1], 1);
      cycle(); settle();
      chk("sat.second_tc", act_tc[1], 0);
      en_v = 0; ov_clr_v = 1;
      cycle(); settle();
      chk("sat.ov_clr", act_ov[1], 0);
      ov_clr_v = 0;

      // ONESHOT with prescale 3, MAX 5
      clr_v = 1; mode_v = 2'd2; up_v = 1;
      cycle();
      clr_v = 0; en_v = 1;
      repeat (17) cycle();
      cycle(); settle();
      chk("oneshot.count", act_cnt[3], 5);
      chk("oneshot.tc", act_tc[3], 1);
      chk("oneshot.ov", act_ov[3], 1);
      chk("oneshot.running", act_run[3], 0);
      repeat (5) cycle();
      cycle(); settle();
      chk("oneshot.hold_count", act_cnt[3], 5);
      chk("oneshot.hold_tc", act_tc[3], 0);
      load_v = 1; ldv_v = 1;
      cycle(); settle();
      chk("oneshot.reload_count", act_cnt[3], 1);
      chk("oneshot.reload_running", act_run[3], 1);
      load_v = 0;
      cycle(); cycle(); settle();
      chk("oneshot.presc_wait", act_cnt[3], 1);
      cycle(); settle();
      chk("oneshot.presc_step", act_cnt[3], 2);

      // priority and load clipping
      mode_v = 2'd0; up_v = 1; en_v = 1; clr_v = 1; load_v = 1; ldv_v = 32'hFF;
      cycle(); settle();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("prio%0d.count", i), act_cnt[i], 0);
         chk($sformatf("prio%0d.tc", i), act_tc[i], 0);
      end
      clr_v = 0;
      cycle(); settle();
      chk("clip.count8", act_cnt[2], 8'h80);
      chk("clip.count4", act_cnt[1], 15);
      load_v = 0;
      cycle(); settle();
      chk("clip.wrap_count", act_cnt[2], 0);
      chk("clip.wrap_tc", act_tc[2], 1);

      // compare match
      clr_v = 1; en_v = 0; cmp_v = 7;
      cycle();
      clr_v = 0; en_v = 1;
      repeat (6) cycle();
      settle();
      chk("cmp.before", act_hit[1], 0);
      cycle(); settle();
      chk("cmp.hit", act_hit[1], 1);
      chk("cmp.count", act_cnt[1], 7);
      chk("cmp.hit16", act_hit[0], 1);
      cycle(); settle();
      chk("cmp.pulse", act_hit[1], 0);
      en_v = 0; load_v = 1; ldv_v = 15; ov_clr_v = 1;
      cycle(); settle();
      chk("ovprio.cleared", act_ov[1], 0);
      load_v = 0; en_v = 1;
      cycle(); settle();
      chk("ovprio.count", act_cnt[1], 0);
      chk("ovprio.set_wins", act_ov[1], 1);
      ov_clr_v = 0;

      // randomized traffic
      repeat (3000) begin
         r = $urandom_range(0, 99);
         clr_v    = (r < 3);
         load_v   = (r >= 3 && r < 10);
         en_v     = ($urandom_range(0, 99) < 85);
         ov_clr_v = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 9) == 0) up_v = !up_v;
         if ($urandom_range(0, 19) == 0) mode_v = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       ldv_v = '0;
            1:       ldv_v = '1;
            2:       ldv_v = $urandom_range(0, 15);
            default: ldv_v = $urandom;
         endcase
         if ($urandom_range(0, 49) == 0) cmp_v = $urandom_range(0, 15);
         cycle();
      end

      // asynchronous reset mid-count
      clr_v = 1; load_v = 0; en_v = 0; ov_clr_v = 0;
      cycle();
      clr_v = 0; load_v = 1; ldv_v = 32'h122F; mode_v = 2'd0; up_v = 1;
      cycle();
      load_v = 0; en_v = 1;
      repeat (5) cycle();
      settle();
      chk("areset.pre_count", act_cnt[0], 16'h1234);
      chk("areset.pre_ov", act_ov[1], 1);
      #1 nrst = 0;
      #1;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("areset%0d.count", i), act_cnt[i], 0);
         chk($sformatf("areset%0d.ov", i), act_ov[i], 0);
         chk($sformatf("areset%0d.tc", i), act_tc[i], 0);
      end
      chk("areset.running", act_run[0], 1);
      settle();
      chk("areset.hold", act_cnt[0], 0);
      en_v = 0; drive();
      @(negedge clk);
      nrst = 1;
      en_v = 1;
      cycle(); settle();
      chk("areset.resume", act_cnt[0], 1);

      repeat (2) @(posedge clk);
      #2;
      chk("scoreboard.drained", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
